mux_4_1_rr_sched: RTL and testbench

- Round-robin scheduler that shares the 4:1 4-bit mux datapath between four requesters (a, b, c, d).
- Drives the mux select, registers the selected word, and presents it on a valid/ready output port.
- Each requester sees a per-port ack when its word is captured.
- A granted requester may keep the datapath for up to BURST consecutive beats before the grant rotates.

---
 rtl/mux_4_1_rr_sched_if.sv | 28 ++
 rtl/mux_4_1_rr_sched.sv | 153 +++++++++++++++
 tb/tb_mux_4_1_rr_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_1_rr_sched_if.sv
// Requester/output bundle for the round-robin 4:1 mux scheduler.
// The slave modport is the scheduler's view. The master modport is the
// environment's view: it drives the requesters and the downstream ready.
interface mux_4_1_rr_sched_if #(
   parameter int WIDTH = 4
);
   logic [3:0]       req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [3:0]       ack;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      output req, a, b, c, d, out_ready,
      input  ack, sel, out, out_valid, busy
   );

   modport slave (
      input  req, a, b, c, d, out_ready,
      output ack, sel, out, out_valid, busy
   );
endinterface

// File: rtl/mux_4_1_rr_sched.sv
// Round-robin scheduler that shares a 4:1 WIDTH-bit mux between four
// requesters. The granted word is registered and offered downstream on a
// valid/ready port. A grant may keep the datapath for up to BURST
// consecutive beats before the scan moves on from the rotating pointer.
module mux_4_1_rr_sched #(
   parameter int WIDTH = 4,
   parameter int BURST = 2      // legal range 1..15
) (
   input logic               clk,
   input logic               reset,
   mux_4_1_rr_sched_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [3:0] BURST_C = 4'(BURST);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [1:0]       sel_q, sel_d;
   logic             out_valid_q, out_valid_d;

   logic             win_found;
   logic [1:0]       win_idx;
   logic             capture;
   logic             extend;
   logic [1:0]       cap_idx;
   logic [WIDTH-1:0] cap_data;

   // Arbitration: the first requester found scanning ptr, ptr+1, ... (mod 4).
   always_comb begin
      logic [1:0] cand;
      // NOTE: combinational blocks use blocking '='; only the clocked block
      // below uses '<='. Every signal also gets a default first, so no path
      // through the block can infer a latch.
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      // Walk from the farthest offset down, so the nearest hit wins.
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Capture decision: choose between a fresh grant, a burst beat, or no capture.
   always_comb begin
      capture = 1'b0;
      extend  = 1'b0;
      cap_idx = win_idx;
      case (state_q)
         IDLE: begin
            capture = win_found;
         end
         HOLD: begin
            if (bus.out_ready) begin
               if ((cnt_q < BURST_C) && bus.req[sel_q]) begin
                  // The current owner still requests and has beats left.
                  capture = 1'b1;
                  extend  = 1'b1;
                  cap_idx = sel_q;
               end else begin
                  // Back-to-back re-arbitration, with no bubble beat.
                  capture = win_found;
               end
            end
         end
         default: begin
            capture = 1'b0;
         end
      endcase
   end

   // Data path: the 4:1 mux that the requesters share.
   always_comb begin
      cap_data = bus.a;
      case (cap_idx)
         2'd0:    cap_data = bus.a;
         2'd1:    cap_data = bus.b;
         2'd2:    cap_data = bus.c;
         default: cap_data = bus.d;
      endcase
   end

   // Next state: load the captured word, or drain to IDLE when nothing is waiting.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q;

      if (capture) begin
         out_d       = cap_data;
         sel_d       = cap_idx;
         out_valid_d = 1'b1;
         state_d     = HOLD;
         if (extend) begin
            cnt_d = cnt_q + 4'd1;
         end else begin
            cnt_d = 4'd1;
            ptr_d = cap_idx + 2'd1;
         end
      end else if ((state_q == HOLD) && bus.out_ready) begin
         // The word was consumed and nobody is requesting. out and sel keep
         // their last values.
         out_valid_d = 1'b0;
         state_d     = IDLE;
      end
   end

   // State registers with synchronous, active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         cnt_q       <= 4'd0;
         out_q       <= '0;
         sel_q       <= 2'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Per-requester ack: one-hot on the edge that captures, held low during reset.
   always_comb begin
      bus.ack = 4'b0000;
      if (capture && !reset) begin
         bus.ack[cap_idx] = 1'b1;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q == HOLD);

endmodule

// File: tb/tb_mux_4_1_rr_sched.sv
// Bench for mux_4_1_rr_sched. A BURST=2 instance and a BURST=1 instance
// receive identical stimulus. Each is compared against a behavioural model
// built from the arbitration rules. Directed scenarios come first, followed
// by randomized traffic.
module tb_mux_4_1_rr_sched;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_4_1_rr_sched_if #(.WIDTH(WIDTH)) bus2 ();
   mux_4_1_rr_sched_if #(.WIDTH(WIDTH)) bus1 ();

   mux_4_1_rr_sched #(.WIDTH(WIDTH), .BURST(2)) dut_b2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   mux_4_1_rr_sched #(.WIDTH(WIDTH), .BURST(1)) dut_b1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model state: index 0 tracks the BURST=2 instance, index 1 the BURST=1 instance.
   int burst_of [2] = '{2, 1};
   bit m_valid  [2];
   int m_out    [2];
   int m_sel    [2];
   int m_ptr    [2];
   int m_beats  [2];

   function automatic int rr_pick(input logic [3:0] rq, input int from);
      for (int k = 0; k < 4; k++)
         if (rq[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   // Advance one model by one clock edge. Returns the requester captured at
   // this edge, or -1 when nothing is captured.
   task automatic model_cycle(input int m, input bit rst, input logic [3:0] rq,
                              input int data [4], input bit rdy, output int grantee);
      bit ext;
      grantee = -1;
      if (rst) begin
         m_valid[m] = 0; m_out[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_beats[m] = 0;
      end else begin
         ext = m_valid[m] && rdy && (m_beats[m] < burst_of[m]) && rq[m_sel[m]];
         if (ext) grantee = m_sel[m];
         else if (!m_valid[m] || rdy) grantee = rr_pick(rq, m_ptr[m]);
         if (grantee >= 0) begin
            m_out[m]   = data[grantee];
            m_sel[m]   = grantee;
            m_valid[m] = 1;
            if (ext) m_beats[m] = m_beats[m] + 1;
            else begin
               m_beats[m] = 1;
               m_ptr[m]   = (grantee + 1) % 4;
            end
         end else if (m_valid[m] && rdy) begin
            m_valid[m] = 0;
         end
      end
   endtask

   // Drive one cycle on both instances, compare both against the model, and
   // advance the model. On return the edge has not happened yet: sel/out/valid/
   // busy still show earlier edges, and ack shows the current cycle.
   task automatic step(input bit rst, input logic [3:0] rq, input int da, input int db,
                       input int dc, input int dd, input bit rdy);
      int data [4];
      int g;
      logic [3:0] exp_ack;
      logic [3:0] g_ack, g_out;
      logic [1:0] g_sel;
      logic       g_ov, g_busy;
      string      nm;
      data = '{da, db, dc, dd};
      @(negedge clk);
      reset = rst;
      bus2.req = rq; bus2.a = WIDTH'(da); bus2.b = WIDTH'(db); bus2.c = WIDTH'(dc); bus2.d = WIDTH'(dd);
      bus2.out_ready = rdy;
      bus1.req = rq; bus1.a = WIDTH'(da); bus1.b = WIDTH'(db); bus1.c = WIDTH'(dc); bus1.d = WIDTH'(dd);
      bus1.out_ready = rdy;
      #1;
      for (int m = 0; m < 2; m++) begin
         if (m == 0) begin
            g_ack = bus2.ack; g_out = bus2.out; g_sel = bus2.sel; g_ov = bus2.out_valid; g_busy = bus2.busy;
         end else begin
            g_ack = bus1.ack; g_out = bus1.out; g_sel = bus1.sel; g_ov = bus1.out_valid; g_busy = bus1.busy;
         end
         nm = $sformatf("burst%0d", burst_of[m]);
         check({nm, ".out"},       32'(g_out),  32'(m_out[m]));
         check({nm, ".sel"},       32'(g_sel),  32'(m_sel[m]));
         check({nm, ".out_valid"}, 32'(g_ov),   32'(m_valid[m]));
         check({nm, ".busy"},      32'(g_busy), 32'(m_valid[m]));
         model_cycle(m, rst, rq, data, rdy, g);
         exp_ack = (g < 0) ? 4'b0000 : (4'b0001 << g);
         check({nm, ".ack"}, 32'(g_ack), 32'(exp_ack));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t4_out [8];
      int t4_sel [8];
      t4_out = '{8, 8, 4, 4, 2, 2, 1, 1};
      t4_sel = '{0, 0, 1, 1, 2, 2, 3, 3};

      reset = 1'b1;
      bus2.req = '0; bus2.a = '0; bus2.b = '0; bus2.c = '0; bus2.d = '0; bus2.out_ready = 1'b0;
      bus1.req = '0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.d = '0; bus1.out_ready = 1'b0;

      // Reset state. ack must stay low even while every requester asks.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      step(1, 4'b1111, 1, 2, 3, 4, 1);
      check("rst.ack", 32'(bus2.ack), 32'(0));
      step(0, 4'b0000, 0, 0, 0, 0, 0);
      check("rst.out", 32'(bus2.out), 32'(0));
      check("rst.sel", 32'(bus2.sel), 32'(0));
      check("rst.out_valid", 32'(bus2.out_valid), 32'(0));
      check("rst.busy", 32'(bus2.busy), 32'(0));

      // 1: one requester, BURST=2. a is re-granted every beat.
      for (int k = 0; k < 6; k++) begin
         step(0, 4'b0001, 1, 0, 0, 0, 1);
         check("t1.ack", 32'(bus2.ack), 32'(4'b0001));
         if (k >= 1) begin
            check("t1.out", 32'(bus2.out), 32'(1));
            check("t1.sel", 32'(bus2.sel), 32'(0));
            check("t1.busy", 32'(bus2.busy), 32'(1));
         end
      end

      // 2: all four requesters, BURST=1. Pure rotation.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         step(0, 4'b1111, 1, 2, 4, 8, 1);
         check("t2.ack", 32'(bus1.ack), 32'(4'b0001 << (k % 4)));
         if (k >= 1) begin
            check("t2.out", 32'(bus1.out), 32'(4'b0001 << ((k - 1) % 4)));
            check("t2.sel", 32'(bus1.sel), 32'((k - 1) % 4));
         end
      end

      // 3: backpressure holds the word. Release with no requesters drains to IDLE.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 4'b0100, 0, 0, 4, 0, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 4'b0000, 0, 0, 0, 0, 0);
         check("t3.out", 32'(bus2.out), 32'(4));
         check("t3.sel", 32'(bus2.sel), 32'(2));
         check("t3.out_valid", 32'(bus2.out_valid), 32'(1));
         check("t3.ack", 32'(bus2.ack), 32'(0));
      end
      step(0, 4'b0000, 0, 0, 0, 0, 1);
      check("t3.valid_last", 32'(bus2.out_valid), 32'(1));
      step(0, 4'b0000, 0, 0, 0, 0, 1);
      check("t3.drop_valid", 32'(bus2.out_valid), 32'(0));
      check("t3.drop_busy", 32'(bus2.busy), 32'(0));

      // 4: BURST=2 with rotation. Each requester gets two beats.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         step(0, 4'b1111, 8, 4, 2, 1, 1);
         if (k >= 1) begin
            check("t4.out", 32'(bus2.out), 32'(t4_out[k - 1]));
            check("t4.sel", 32'(bus2.sel), 32'(t4_sel[k - 1]));
         end
      end

      // 5: pointer wrap. After a grant to d the scan starts at a, so b wins over d.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 4'b1000, 0, 0, 0, 5, 1);
      step(0, 4'b0000, 0, 0, 0, 0, 1);
      step(0, 4'b1010, 0, 6, 0, 5, 1);
      check("t5.ack_b2", 32'(bus2.ack), 32'(4'b0010));
      check("t5.ack_b1", 32'(bus1.ack), 32'(4'b0010));
      step(0, 4'b0000, 0, 0, 0, 0, 1);
      check("t5.sel_b2", 32'(bus2.sel), 32'(1));
      check("t5.sel_b1", 32'(bus1.sel), 32'(1));

      // 6: reset while a word is held. The word is discarded and the pointer returns to a.
      step(1, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 4'b0001, 8, 0, 0, 0, 0);
      step(0, 4'b0000, 0, 0, 0, 0, 0);
      check("t6.held", 32'(bus2.out), 32'(8));
      step(1, 4'b1111, 8, 4, 2, 1, 1);
      check("t6.rst_ack", 32'(bus2.ack), 32'(0));
      step(0, 4'b1111, 8, 4, 2, 1, 1);
      check("t6.out", 32'(bus2.out), 32'(0));
      check("t6.sel", 32'(bus2.sel), 32'(0));
      check("t6.out_valid", 32'(bus2.out_valid), 32'(0));
      check("t6.first_grant", 32'(bus2.ack), 32'(4'b0001));

      // Randomized traffic: occasional resets, random requests, data and ready.
      for (int n = 0; n < 2000; n++) begin
         step(($urandom_range(0, 49) == 0),
              4'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 9) < 7));
      end

      step(0, 4'b0000, 0, 0, 0, 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
